inventory_ctrl: RTL

//  - Owns the 7-item stock vector (3 bits/item) that drives the admin stock display and the

---
 rtl/vend_pkg.sv | 26 ++
 rtl/inventory_ctrl_rr_arb2.sv | 34 +++
 rtl/inventory_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the inventory controller.
//   N_ITEMS / CNT_W / MAX_STOCK / INIT_STOCK : stock geometry and limits
//   state_t : transaction FSM states
//   src_t   : requester identity (customer buy or admin restock)
//   field_lsb() : item ID -> bit offset of that item's field in the stock vector
package vend_pkg;
    localparam int N_ITEMS    = 7;
    localparam int CNT_W      = 3;
    localparam int MAX_STOCK  = 7;
    localparam int INIT_STOCK = 5;
    localparam int ID_W       = 3;
    localparam int LEFT_W     = N_ITEMS * CNT_W;
    localparam int OFF_W      = $clog2(LEFT_W);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, WAIT} state_t;
    typedef enum logic {SRC_BUY, SRC_RS} src_t;

    // ID 0 maps to offset 0 so the read stays in range; callers refuse ID 0
    // before anything is written.
    function automatic logic [OFF_W-1:0] field_lsb(input logic [ID_W-1:0] id);
        logic [OFF_W-1:0] idx;
        if (id == '0) return '0;
        idx = OFF_W'(id) - OFF_W'(1);
        return OFF_W'(idx * OFF_W'(CNT_W));
    endfunction
endpackage

// File: rtl/inventory_ctrl_rr_arb2.sv
// Two-way round-robin arbiter between the buy and restock requesters.
//   clk, rst  : clock, synchronous active-high reset (pointer -> SRC_BUY)
//   req_buy   : customer purchase request
//   req_rs    : admin restock request
//   advance   : a grant is being taken this cycle; move the pointer
//   gnt_src   : side that wins if a grant is taken now
module rr_arb2
    import vend_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_buy,
    input  logic req_rs,
    input  logic advance,
    output src_t gnt_src
);
    src_t rr_ptr;

    // A lone request always wins; the pointer only breaks ties.
    always_comb begin
        gnt_src = SRC_BUY;
        if (req_rs && (!req_buy || rr_ptr == SRC_RS))
            gnt_src = SRC_RS;
    end

    // Pointer moves to the side that just lost, so a waiting requester is
    // never passed over more than once.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= SRC_BUY;
        else if (advance)
            rr_ptr <= (gnt_src == SRC_RS) ? SRC_BUY : SRC_RS;
    end
endmodule

// File: rtl/inventory_ctrl.sv
// Inventory controller: owns the per-item stock vector and serialises
// customer purchases and admin restocks through one transaction FSM.
//   clk, rst                  : clock, synchronous active-high reset
//   buy_req/buy_item/buy_qty  : purchase request (level, held until answered)
//   buy_ack/buy_nack          : one-cycle purchase result pulses
//   rs_req/rs_item/rs_qty     : restock request (level, held until answered)
//   rs_ack/rs_nack/rs_sat     : one-cycle restock result pulses, sat with ack
//   left                      : stock vector, item k at [3k-1:3k-3]
//   sold_out                  : bit k-1 set when item k stock is zero
//   busy                      : FSM not in IDLE
//
// state  | meaning
// IDLE   | no transaction; grant a pending request and latch it
// CHECK  | evaluate the latched request against current stock
// COMMIT | write the new stock field and pulse ack/nack
// WAIT   | hold until the served requester drops its request
module inventory_ctrl
    import vend_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    buy_req,
    input  logic [ID_W-1:0]         buy_item,
    input  logic [CNT_W-1:0]        buy_qty,
    output logic                    buy_ack,
    output logic                    buy_nack,
    input  logic                    rs_req,
    input  logic [ID_W-1:0]         rs_item,
    input  logic [CNT_W-1:0]        rs_qty,
    output logic                    rs_ack,
    output logic                    rs_nack,
    output logic                    rs_sat,
    output logic [LEFT_W-1:0]       left,
    output logic [N_ITEMS-1:0]      sold_out,
    output logic                    busy
);
    state_t           state_q, state_d;
    src_t             gnt_src, src_q;
    logic             grant;
    logic [ID_W-1:0]  item_q;
    logic [CNT_W-1:0] qty_q;
    logic             res_ok_q, res_sat_q;
    logic [CNT_W-1:0] res_val_q;

    logic [OFF_W-1:0] off;
    logic [CNT_W-1:0] cur;
    logic [CNT_W:0]   sum;
    logic             chk_ok, chk_sat;
    logic [CNT_W-1:0] chk_val;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_buy (buy_req),
        .req_rs  (rs_req),
        .advance (grant),
        .gnt_src (gnt_src)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (buy_req || rs_req) begin
                    grant   = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK:  state_d = COMMIT;
            COMMIT: state_d = WAIT;
            WAIT: begin
                if (!((src_q == SRC_RS) ? rs_req : buy_req))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign busy = (state_q != IDLE);

    // Sum is one bit wider than a field so restock overflow is visible.
    always_comb begin
        off     = field_lsb(item_q);
        cur     = left[off +: CNT_W];
        sum     = {1'b0, cur} + {1'b0, qty_q};
        chk_ok  = 1'b0;
        chk_sat = 1'b0;
        chk_val = cur;
        if (src_q == SRC_BUY) begin
            chk_ok  = (item_q != '0) && (qty_q != '0) && (qty_q <= cur);
            chk_val = cur - qty_q;
        end else begin
            chk_ok = (item_q != '0);
            if (sum > (CNT_W+1)'(MAX_STOCK)) begin
                chk_val = CNT_W'(MAX_STOCK);
                chk_sat = 1'b1;
            end else begin
                chk_val = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= SRC_BUY;
            item_q    <= '0;
            qty_q     <= '0;
            res_ok_q  <= 1'b0;
            res_sat_q <= 1'b0;
            res_val_q <= '0;
            left      <= {N_ITEMS{CNT_W'(INIT_STOCK)}};
            buy_ack   <= 1'b0;
            buy_nack  <= 1'b0;
            rs_ack    <= 1'b0;
            rs_nack   <= 1'b0;
            rs_sat    <= 1'b0;
        end else begin
            buy_ack  <= 1'b0;
            buy_nack <= 1'b0;
            rs_ack   <= 1'b0;
            rs_nack  <= 1'b0;
            rs_sat   <= 1'b0;
            if (grant) begin
                src_q  <= gnt_src;
                item_q <= (gnt_src == SRC_RS) ? rs_item : buy_item;
                qty_q  <= (gnt_src == SRC_RS) ? rs_qty  : buy_qty;
            end
            if (state_q == CHECK) begin
                res_ok_q  <= chk_ok;
                res_sat_q <= chk_sat;
                res_val_q <= chk_val;
            end
            if (state_q == COMMIT) begin
                if (res_ok_q)
                    left[off +: CNT_W] <= res_val_q;
                if (src_q == SRC_BUY) begin
                    buy_ack  <= res_ok_q;
                    buy_nack <= !res_ok_q;
                end else begin
                    rs_ack  <= res_ok_q;
                    rs_nack <= !res_ok_q;
                    rs_sat  <= res_ok_q && res_sat_q;
                end
            end
        end
    end

    for (genvar k = 0; k < N_ITEMS; k++) begin : g_sold
        assign sold_out[k] = (left[k*CNT_W +: CNT_W] == '0);
    end
endmodule
